// File: rtl/mem_stage_lsu.sv
// Memory-access pipeline stage: registers EX results, waits for load data from a
// variable-latency memory, extracts/extends it and drives WB and ID forwarding.
module mem_stage_lsu #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_load,
  input  logic [2:0]        ex_ld_type,
  input  logic              ex_rf_we,
  input  logic [4:0]        ex_rf_waddr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [PC_W-1:0]   wb_pc,
  output logic              wb_we,
  output logic [4:0]        wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              fwd_we,
  output logic [4:0]        fwd_waddr,
  output logic [DATA_W-1:0] fwd_wdata,
  output logic              fwd_pending,
  output logic              stall_req,
  output logic              align_err,
  output logic              bus_err
);

  localparam int         LANE_W   = $clog2(DATA_W / 8);
  localparam bit         IS64     = (DATA_W == 64);
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                load_q, load_d;
  logic [2:0]          ld_type_q, ld_type_d;
  logic                rf_we_q, rf_we_d;
  logic [4:0]          waddr_q, waddr_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [9:0]          cnt_q, cnt_d;
  logic                align_err_q, align_err_d;

  logic [DATA_W-1:0]   ext_s;
  logic                ex_mis_s;
  logic                waiting_s;
  logic                stall_unused_s;

  function automatic logic [DATA_W-1:0] extract(input logic [2:0]        ld_type,
                                                input logic [LANE_W-1:0] lane,
                                                input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (ld_type)
      3'b000:  return DATA_W'($signed(sh[7:0]));
      3'b001:  return DATA_W'(sh[7:0]);
      3'b010:  return DATA_W'($signed(sh[15:0]));
      3'b011:  return DATA_W'(sh[15:0]);
      3'b100:  return DATA_W'($signed(sh[31:0]));
      3'b101:  return IS64 ? DATA_W'(sh[31:0]) : DATA_W'($signed(sh[31:0]));
      3'b110:  return IS64 ? sh : DATA_W'($signed(sh[31:0]));
      default: return {DATA_W{1'b0}};
    endcase
  endfunction

  // On a 32-bit datapath the upper lane bit is zero, so LD checks word alignment.
  function automatic logic misaligned(input logic [2:0]        ld_type,
                                      input logic [LANE_W-1:0] lane);
    logic [2:0] l3;
    l3 = 3'(lane);
    case (ld_type)
      3'b010, 3'b011: return l3[0];
      3'b100, 3'b101: return |l3[1:0];
      3'b110:         return |l3;
      default:        return 1'b0;
    endcase
  endfunction

  assign ext_s          = extract(ld_type_q, result_q[LANE_W-1:0], mem_rdata);
  assign ex_mis_s       = misaligned(ex_ld_type, ex_result[LANE_W-1:0]);
  assign waiting_s      = (state_q == S_WAIT) && !mem_rvalid;
  assign stall_unused_s = ^{stall[5], stall[2:0]};

  // Next-state: load FSM progress, then register update (bubble > capture > hold).
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    pc_d        = pc_q;
    load_d      = load_q;
    ld_type_d   = ld_type_q;
    rf_we_d     = rf_we_q;
    waddr_d     = waddr_q;
    result_d    = result_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    align_err_d = 1'b0;

    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q + 10'd1;
        if (mem_rvalid) begin
          buf_d   = ext_s;
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          buf_d   = {DATA_W{1'b0}};
          rf_we_d = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = state_q;
    endcase

    if (stall[3] && !stall[4]) begin
      state_d   = S_IDLE;
      valid_d   = 1'b0;
      pc_d      = {PC_W{1'b0}};
      load_d    = 1'b0;
      ld_type_d = 3'b000;
      rf_we_d   = 1'b0;
      waddr_d   = 5'd0;
      result_d  = {DATA_W{1'b0}};
      buf_d     = {DATA_W{1'b0}};
      cnt_d     = 10'd0;
    end else if (!stall[3]) begin
      valid_d   = ex_valid;
      pc_d      = ex_pc;
      load_d    = ex_load;
      ld_type_d = ex_ld_type;
      rf_we_d   = ex_rf_we;
      waddr_d   = ex_rf_waddr;
      result_d  = ex_result;
      buf_d     = {DATA_W{1'b0}};
      cnt_d     = 10'd0;
      if (ex_valid && ex_load) begin
        if (ex_mis_s) begin
          // Misaligned loads never touch memory: complete at once with no write.
          state_d     = S_DONE;
          rf_we_d     = 1'b0;
          align_err_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      align_err_d = 1'b0;
    end
  end

  // State and pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      valid_q     <= 1'b0;
      pc_q        <= {PC_W{1'b0}};
      load_q      <= 1'b0;
      ld_type_q   <= 3'b000;
      rf_we_q     <= 1'b0;
      waddr_q     <= 5'd0;
      result_q    <= {DATA_W{1'b0}};
      buf_q       <= {DATA_W{1'b0}};
      cnt_q       <= 10'd0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      load_q      <= load_d;
      ld_type_q   <= ld_type_d;
      rf_we_q     <= rf_we_d;
      waddr_q     <= waddr_d;
      result_q    <= result_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      align_err_q <= align_err_d;
    end
  end

  // WB data select; a response in WAIT bypasses the buffer so zero-wait loads cost nothing.
  always_comb begin
    wb_we    = 1'b0;
    wb_wdata = {DATA_W{1'b0}};
    if (valid_q && load_q) begin
      case (state_q)
        S_WAIT: begin
          if (mem_rvalid) begin
            wb_we    = rf_we_q;
            wb_wdata = ext_s;
          end else begin
            wb_we    = 1'b0;
            wb_wdata = {DATA_W{1'b0}};
          end
        end
        S_DONE: begin
          wb_we    = rf_we_q;
          wb_wdata = buf_q;
        end
        default: begin
          wb_we    = 1'b0;
          wb_wdata = {DATA_W{1'b0}};
        end
      endcase
    end else begin
      wb_we    = rf_we_q && valid_q;
      wb_wdata = result_q;
    end
  end

  assign wb_pc       = pc_q;
  assign wb_waddr    = waddr_q;
  assign fwd_we      = wb_we;
  assign fwd_waddr   = waddr_q;
  assign fwd_wdata   = wb_wdata;
  assign fwd_pending = waiting_s;
  assign stall_req   = waiting_s;
  assign align_err   = align_err_q;
  assign bus_err     = waiting_s && (cnt_q == TMO_LAST);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a table of single-slot vectors plus
// hand-written multi-cycle sequences for latency, stall, timeout and reset.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        ex_valid, ex_load, ex_rf_we;
  logic [31:0] ex_pc, ex_result;
  logic [2:0]  ex_ld_type;
  logic [4:0]  ex_rf_waddr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] wb_pc, wb_wdata, fwd_wdata;
  logic        wb_we, fwd_we, fwd_pending, stall_req, align_err, bus_err;
  logic [4:0]  wb_waddr, fwd_waddr;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu #(.DATA_W(32), .PC_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_load(ex_load), .ex_ld_type(ex_ld_type),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_pc(wb_pc), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_pending(fwd_pending), .stall_req(stall_req),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        load;
    logic [2:0]  ld_type;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_we;
    logic [31:0] e_wdata;
    logic        e_align;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic ld, input logic [2:0] t, input logic we,
                          input logic [4:0] wa, input logic [31:0] res, input logic [31:0] pc);
    ex_valid    = v;
    ex_load     = ld;
    ex_ld_type  = t;
    ex_rf_we    = we;
    ex_rf_waddr = wa;
    ex_result   = res;
    ex_pc       = pc;
  endtask

  initial begin
    //            valid load type   we  waddr  result        rv    rdata         e_we  e_wdata       e_al
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 1'b1, 5'd5,  32'h1234_5678, 1'b0, 32'h0,         1'b1, 32'h1234_5678, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 3'b000, 1'b1, 5'd1,  32'h0000_1003, 1'b1, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 3'b001, 1'b1, 5'd2,  32'h0000_1003, 1'b1, 32'h80FF_0000, 1'b1, 32'h0000_0080, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 3'b010, 1'b1, 5'd3,  32'h0000_2002, 1'b1, 32'hBEEF_1234, 1'b1, 32'hFFFF_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 3'b011, 1'b1, 5'd4,  32'h0000_2002, 1'b1, 32'hBEEF_1234, 1'b1, 32'h0000_BEEF, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 3'b100, 1'b1, 5'd6,  32'h0000_3000, 1'b1, 32'h89AB_CDEF, 1'b1, 32'h89AB_CDEF, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 3'b000, 1'b1, 5'd7,  32'h0000_1001, 1'b1, 32'h0000_7F00, 1'b1, 32'h0000_007F, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 3'b100, 1'b1, 5'd8,  32'h0000_3002, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 1'b1, 3'b011, 1'b1, 5'd9,  32'h0000_2001, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'b000, 1'b0, 5'd10, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 3'b000, 1'b1, 5'd11, 32'h55AA_55AA, 1'b0, 32'h0,         1'b0, 32'h55AA_55AA, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 3'b110, 1'b1, 5'd12, 32'h0000_4004, 1'b1, 32'h8000_0001, 1'b1, 32'h8000_0001, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 3'b101, 1'b1, 5'd13, 32'h0000_4000, 1'b1, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 3'b000, 1'b0, 5'd14, 32'h0000_5000, 1'b1, 32'h0000_00C3, 1'b0, 32'hFFFF_FFC3, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 3'b110, 1'b1, 5'd15, 32'h0000_4006, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1};

    rst = 1'b1;
    stall = 6'b000000;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    drive_ex(1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_wb_we", 64'(wb_we), 64'd0);
    chk("rst_wb_wdata", 64'(wb_wdata), 64'd0);
    chk("rst_wb_pc", 64'(wb_pc), 64'd0);
    chk("rst_wb_waddr", 64'(wb_waddr), 64'd0);
    chk("rst_flags", 64'({stall_req, fwd_pending, align_err, bus_err}), 64'd0);
    rst = 1'b0;

    // Table: each slot is captured, then checked in its first MEM cycle.
    for (int i = 0; i < 15; i++) begin
      drive_ex(vecs[i].valid, vecs[i].load, vecs[i].ld_type, vecs[i].we, vecs[i].waddr,
               vecs[i].result, 32'h100 + 32'(i * 4));
      mem_rvalid = 1'b0;
      tick();
      mem_rvalid = vecs[i].rvalid;
      mem_rdata  = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_we", i), 64'(wb_we), 64'(vecs[i].e_we));
      chk($sformatf("v%0d_wdata", i), 64'(wb_wdata), 64'(vecs[i].e_wdata));
      chk($sformatf("v%0d_waddr", i), 64'(wb_waddr), 64'(vecs[i].waddr));
      chk($sformatf("v%0d_pc", i), 64'(wb_pc), 64'(32'h100 + 32'(i * 4)));
      chk($sformatf("v%0d_align", i), 64'(align_err), 64'(vecs[i].e_align));
      chk($sformatf("v%0d_stall", i), 64'({stall_req, fwd_pending}), 64'd0);
      chk($sformatf("v%0d_fwd", i), 64'({fwd_we, fwd_waddr, fwd_wdata}),
          64'({vecs[i].e_we, vecs[i].waddr, vecs[i].e_wdata}));
    end
    mem_rvalid = 1'b0;

    // LH with three wait cycles, next slot held at the EX input.
    drive_ex(1'b1, 1'b1, 3'b010, 1'b1, 5'd7, 32'h0000_2000, 32'h200);
    tick();
    drive_ex(1'b1, 1'b0, 3'b000, 1'b1, 5'd9, 32'h0000_0099, 32'h204);
    stall = 6'b011111;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("lat_wait%0d", k), 64'({stall_req, fwd_pending, wb_we}), 64'b110);
      tick();
    end
    stall = 6'b000000;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_8001;
    #1;
    chk("lat_data", 64'({wb_we, wb_waddr, wb_wdata}), 64'({1'b1, 5'd7, 32'hFFFF_8001}));
    chk("lat_nostall", 64'({stall_req, fwd_pending}), 64'd0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("lat_next", 64'({wb_we, wb_waddr, wb_wdata}), 64'({1'b1, 5'd9, 32'h0000_0099}));

    // Response arrives under an external hold, is buffered, then a bubble clears.
    drive_ex(1'b1, 1'b1, 3'b100, 1'b1, 5'd4, 32'h0000_0010, 32'h300);
    tick();
    drive_ex(1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0);
    stall = 6'b011111;
    #1;
    chk("hold_wait", 64'(stall_req), 64'd1);
    tick();
    stall = 6'b011000;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("hold_resp", 64'({wb_we, wb_wdata, stall_req}), 64'({1'b1, 32'hDEAD_BEEF, 1'b0}));
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("hold_done", 64'({wb_we, wb_wdata, stall_req, fwd_pending}), 64'({1'b1, 32'hDEAD_BEEF, 2'b00}));
    chk("hold_pc", 64'(wb_pc), 64'(32'h300));
    stall = 6'b001000;
    tick();
    stall = 6'b000000;
    #1;
    chk("bubble", 64'({wb_we, wb_waddr, wb_wdata, wb_pc}), 64'd0);

    // Timeout with TIMEOUT=4.
    drive_ex(1'b1, 1'b1, 3'b100, 1'b1, 5'd3, 32'h0000_0020, 32'h400);
    tick();
    drive_ex(1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0);
    stall = 6'b011111;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk($sformatf("tmo_stall%0d", k), 64'({stall_req, wb_we}), 64'b10);
      chk($sformatf("tmo_buserr%0d", k), 64'(bus_err), 64'(k == 4));
      tick();
    end
    stall = 6'b011000;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("tmo_done", 64'({wb_we, wb_wdata, stall_req, bus_err}), 64'd0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("tmo_ignore", 64'({wb_we, wb_wdata, stall_req}), 64'd0);
    stall = 6'b000000;
    tick();

    // Reset in the middle of WAIT, then a late response.
    drive_ex(1'b1, 1'b1, 3'b010, 1'b1, 5'd6, 32'h0000_0030, 32'h500);
    tick();
    drive_ex(1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0);
    stall = 6'b011111;
    #1;
    chk("rstw_wait", 64'(stall_req), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 6'b000000;
    #1;
    chk("rstw_out", 64'({wb_we, wb_waddr, wb_wdata, wb_pc}), 64'd0);
    chk("rstw_flags", 64'({stall_req, fwd_pending, align_err, bus_err}), 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_1234;
    #1;
    chk("rstw_late", 64'({wb_we, wb_wdata, stall_req}), 64'd0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("rstw_after", 64'({wb_we, wb_wdata, stall_req, bus_err}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
